mul: RTL and testbench
======================

// Module: mul
// PURPOSE
//   Sequential unsigned shift-add multiplier: result = a * b, one partial product per clock.
//   Standalone arithmetic block with a start/busy handshake; result is held until the next op.
//   Trades latency (WIDTH cycles) for area; no hardware multiplier inferred.
// PARAMETERS
//   WIDTH  8  operand width in bits; result is 2*WIDTH bits
// PORTS
//   clk     in   1        single clock, rising-edge active
//   rst     in   1        asynchronous, active-high reset
//   a       in   WIDTH    multiplicand, unsigned, sampled when start accepted
//   b       in   WIDTH    multiplier, unsigned, sampled when start accepted
//   start   in   1        request; accepted on a rising clk edge while idle
//   result  out  2*WIDTH  product of last completed operation
//   busy    out  1        high while an operation is in progress
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, busy=0, result=0, all internal regs=0; overrides all.
//   - States: IDLE, RUN. No other states.
//   - IDLE: start=1 at edge -> latch mcand={WIDTH'b0,a}, mplr=b, acc=0, cnt=0; busy=1; go RUN.
//   - RUN, each edge: if mplr[0] acc+=mcand (2*WIDTH wide, no overflow possible);
//     mcand<<=1; mplr>>=1; cnt++.
//   - Completion on the edge performing iteration WIDTH: result<=final acc, busy<=0, go IDLE.
//   - Latency: busy high for exactly WIDTH edges after the accepting edge (8 for default);
//     result valid the same cycle busy falls.
//   - result holds previous product throughout RUN; changes only at completion or reset.
//   - start while busy is ignored (no restart, no queueing); a,b changes during RUN ignored.
//   - start held high continuously: new op accepted on first idle edge after completion.
//   - Back-to-back: start may be accepted on the edge immediately after busy falls.
//   - rst mid-operation: op aborted, result=0, busy=0 immediately (async).
//   - Operands 0: product 0, full latency (unless early exit compiled in).
// CONFIGURATION
//   MUL_EARLY_EXIT_EN defined: completion occurs on the edge where the shifted mplr becomes 0
//     (after that edge's add); latency = max(1, index of highest set bit of b + 1) cycles;
//     b=0 -> 1 cycle, result 0. Product identical to non-early build.
//   Not defined: fixed WIDTH-cycle latency regardless of operands (constant-time).
// TESTING
//   - rst pulse, then start with a=3,b=2 -> busy=1 for 8 cycles, then result=6, busy=0.
//   - a=5,b=5 -> result=25; a=4,b=3 -> result=12; result stable until next start.
//   - a=255,b=255 -> result=65025; a=0,b=100 -> 0; a=100,b=0 -> 0.
//   - start pulsed mid-op with a=7,b=7 during 3*2 run -> result=6, no restart, latency unchanged.
//   - rst asserted mid-op (a=9,b=9) -> busy=0, result=0 without clock edge; next op correct.
//   - MUL_EARLY_EXIT_EN: a=3,b=2 -> done in 2 cycles, result=6; b=0 -> 1 cycle, result=0.

Source files
------------

// File: rtl/mul.sv
// Sequential unsigned shift-add multiplier: one partial product per clock, start/busy handshake.
// Optional MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]     mplr_q;
  logic [WIDTH-1:0]     mplr_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 last_d;

  always_comb begin
    acc_d = acc_q;
    if (mplr_q[0]) acc_d = acc_q + mcand_q;
    mplr_d = mplr_q >> 1;
    last_d = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
    // Nothing left to add once the shifted multiplier is empty.
    last_d = last_d || (mplr_d == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mplr_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= {{WIDTH{1'b0}}, a};
            mplr_q  <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_d) begin
            result_q <= acc_d;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mul.sv
// Directed self-checking bench for mul: products, latency, result hold, ignored restarts, async reset.
module tb_mul;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        start;
  logic [15:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mul #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .start  (start),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] bv);
`ifdef MUL_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < 8; i++) if (bv[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  // Starts an op, optionally pulses start with other operands mid-run, checks hold, latency, product.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] exp_p, input int pulse_at);
    logic [15:0] prev;
    int cycles;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1);
    prev = result;
    cycles = 0;
    while (busy && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (pulse_at != 0 && cycles == pulse_at) begin
        a = 8'd7; b = 8'd7; start = 1'b1;
      end
      if (pulse_at != 0 && cycles == pulse_at + 1) start = 1'b0;
      if (busy && cycles == 1) check({tag, "_hold"}, result, prev);
    end
    start = 1'b0;
    check({tag, "_latency"}, cycles, exp_lat(bv));
    check({tag, "_result"}, result, exp_p);
  endtask

  initial begin
    int cycles;
    rst = 1'b1; a = '0; b = '0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op("3x2", 8'd3, 8'd2, 16'd6, 0);
    repeat (3) @(posedge clk);
    #1;
    check("3x2_stable", result, 6);
    do_op("5x5", 8'd5, 8'd5, 16'd25, 0);
    do_op("4x3", 8'd4, 8'd3, 16'd12, 0);
    do_op("255x255", 8'd255, 8'd255, 16'd65025, 0);
    do_op("0x100", 8'd0, 8'd100, 16'd0, 0);
    do_op("100x0", 8'd100, 8'd0, 16'd0, 0);
    do_op("midstart", 8'd3, 8'd2, 16'd6, 3);
    check("midstart_idle", busy, 0);

    // start held high: next op accepted on the edge right after completion
    @(negedge clk);
    a = 8'd4; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (busy && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("held_result", result, 12);
    a = 8'd2; b = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    check("held_reaccept", busy, 1);
    cycles = 0;
    while (busy && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("held_latency", cycles, exp_lat(8'd11));
    check("held_result2", result, 22);

    // asynchronous reset in the middle of an op
    @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("9x9", 8'd9, 8'd9, 16'd81, 0);
    do_op("15x128", 8'd15, 8'd128, 16'd1920, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
